// File: rtl/sap2_loader.sv
// Program loader / run sequencer for the sap2_mini CPU: streams an image into CPU memory,
// clears the CPU, runs it for a fixed budget and captures its output. Optional checksum: SAP2_LOADER_CHECKSUM_EN.
module sap2_loader #(
    parameter int HOLD_CYCLES = 2,
    parameter int CLR_CYCLES  = 2,
    parameter int RUN_CYCLES  = 256
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [7:0]  len,
    input  logic        abort,
    input  logic        in_valid,
    input  logic [11:0] in_data,
    output logic        in_ready,
    output logic        cpu_prog,
    output logic        cpu_clr,
    output logic [7:0]  cpu_a,
    output logic [11:0] cpu_d,
    input  logic [11:0] cpu_out,
`ifdef SAP2_LOADER_CHECKSUM_EN
    output logic [11:0] chk,
    input  logic [11:0] chk_exp,
    output logic        chk_err,
`endif
    output logic        busy,
    output logic        done,
    output logic [11:0] result
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_CLR_PRE   = 3'd1;
    localparam logic [2:0] S_LOAD_WAIT = 3'd2;
    localparam logic [2:0] S_LOAD_HOLD = 3'd3;
    localparam logic [2:0] S_CLR_POST  = 3'd4;
    localparam logic [2:0] S_RUN       = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;

    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] CLR_LAST  = 16'(CLR_CYCLES - 1);
    localparam logic [15:0] RUN_LAST  = 16'(RUN_CYCLES - 1);

    logic [2:0]  state;
    logic [2:0]  state_nx;
    logic [15:0] cnt;
    logic [7:0]  addr;
    logic [7:0]  addr_inc;
    logic [7:0]  len_q;
    logic        idle_like;
    logic        start_take;
    logic        abort_hit;
    logic        word_take;
    logic        timed;
    logic        chk_bad;

`ifdef SAP2_LOADER_CHECKSUM_EN
    assign chk_bad = (chk != chk_exp);
`else
    assign chk_bad = 1'b0;
`endif

    assign addr_inc = addr + 8'd1;

    // NOTE: every signal assigned in this block gets a default first so no latch is inferred.
    always_comb begin
        state_nx   = state;
        abort_hit  = 1'b0;
        idle_like  = (state == S_IDLE) || (state == S_DONE);
        start_take = idle_like && start;
        word_take  = 1'b0;
        timed      = 1'b0;
        if (abort && !idle_like) begin
            state_nx  = S_IDLE;
            abort_hit = 1'b1;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) state_nx = S_CLR_PRE;
                end
                S_CLR_PRE: begin
                    timed = 1'b1;
                    if (cnt == CLR_LAST) begin
                        if (len_q != 8'd0) state_nx = S_LOAD_WAIT;
                        else               state_nx = chk_bad ? S_DONE : S_CLR_POST;
                    end
                end
                S_LOAD_WAIT: begin
                    if (in_valid) begin
                        word_take = 1'b1;
                        state_nx  = S_LOAD_HOLD;
                    end
                end
                S_LOAD_HOLD: begin
                    timed = 1'b1;
                    if (cnt == HOLD_LAST) begin
                        if (addr_inc != len_q) state_nx = S_LOAD_WAIT;
                        else                   state_nx = chk_bad ? S_DONE : S_CLR_POST;
                    end
                end
                S_CLR_POST: begin
                    timed = 1'b1;
                    if (cnt == CLR_LAST) state_nx = S_RUN;
                end
                S_RUN: begin
                    timed = 1'b1;
                    if (cnt == RUN_LAST) state_nx = S_DONE;
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up exactly with the state they describe.
    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= S_IDLE;
            cnt      <= 16'd0;
            addr     <= 8'd0;
            len_q    <= 8'd0;
            in_ready <= 1'b0;
            cpu_prog <= 1'b0;
            cpu_clr  <= 1'b0;
            cpu_a    <= 8'd0;
            cpu_d    <= 12'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= 12'd0;
        end else begin
            state    <= state_nx;
            cnt      <= (timed && state_nx == state) ? cnt + 16'd1 : 16'd0;
            in_ready <= (state_nx == S_LOAD_WAIT);
            cpu_prog <= (state_nx == S_LOAD_WAIT) || (state_nx == S_LOAD_HOLD);
            cpu_clr  <= (state_nx == S_CLR_PRE) || (state_nx == S_CLR_POST) || abort_hit;
            busy     <= (state_nx != S_IDLE) && (state_nx != S_DONE);
            done     <= (state_nx == S_DONE);
            if (start_take) begin
                len_q <= len;
                addr  <= 8'd0;
            end
            if (word_take) begin
                cpu_a <= addr;
                cpu_d <= in_data;
            end
            if (state == S_LOAD_HOLD && state_nx != S_LOAD_HOLD && !abort_hit) addr <= addr_inc;
            if (state == S_RUN && state_nx == S_DONE) result <= cpu_out;
        end
    end

`ifdef SAP2_LOADER_CHECKSUM_EN
    // Running image sum; a mismatch at the end of loading skips the post-clear and run.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            chk     <= 12'd0;
            chk_err <= 1'b0;
        end else if (start_take) begin
            chk     <= 12'd0;
            chk_err <= 1'b0;
        end else begin
            if (word_take) chk <= chk + in_data;
            if (state_nx == S_DONE && (state == S_CLR_PRE || state == S_LOAD_HOLD)) chk_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sap2_loader.sv
// Self-checking bench for sap2_loader: directed and randomized jobs against a reference model
// of the expected memory image, clear pulses, timing and captured result.
module tb_sap2_loader;

    localparam int HOLD = 2;
    localparam int CLRC = 2;
    localparam int RUN  = 40;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [7:0]  len;
    logic        abort;
    logic        in_valid;
    logic [11:0] in_data;
    logic        in_ready;
    logic        cpu_prog;
    logic        cpu_clr;
    logic [7:0]  cpu_a;
    logic [11:0] cpu_d;
    logic [11:0] cpu_out;
    logic        busy;
    logic        done;
    logic [11:0] result;
`ifdef SAP2_LOADER_CHECKSUM_EN
    logic [11:0] chk;
    logic [11:0] chk_exp;
    logic        chk_err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [11:0] words [256];
    logic [11:0] exp_mem [256];
    logic [11:0] model_result;

    always #5 clk = ~clk;

    sap2_loader #(.HOLD_CYCLES(HOLD), .CLR_CYCLES(CLRC), .RUN_CYCLES(RUN)) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .len      (len),
        .abort    (abort),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .cpu_prog (cpu_prog),
        .cpu_clr  (cpu_clr),
        .cpu_a    (cpu_a),
        .cpu_d    (cpu_d),
        .cpu_out  (cpu_out),
`ifdef SAP2_LOADER_CHECKSUM_EN
        .chk      (chk),
        .chk_exp  (chk_exp),
        .chk_err  (chk_err),
`endif
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    // Toy CPU: memory written while prog is high; when not cleared it steps through addresses 0..7.
    logic [11:0] cpu_mem [256];
    logic [7:0]  step = 8'd0;

    function automatic logic [11:0] init_val(input int i);
        return 12'((i * 37 + 5) & 12'hfff);
    endfunction

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) cpu_mem[i] <= init_val(i);
            step <= 8'd0;
        end else begin
            if (cpu_prog) cpu_mem[cpu_a] <= cpu_d;
            if (cpu_clr) step <= 8'd0;
            else         step <= step + 8'd1;
        end
    end
    assign cpu_out = cpu_mem[{5'd0, step[2:0]}];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode: 0 valid always high, 1 valid toggles each cycle, 2 random valid plus stray start/len while busy.
    // abort_seg > 0 aborts on the first cycle of that word's hold. chk_delta offsets the expected checksum.
    task automatic run_job(input int n, input int mode, input int abort_seg, input int chk_delta);
        int cyc, acc, rises, clr_hi, clr_rises, segs;
        int seg_len [256];
        logic [7:0]  seg_a [256];
        logic [11:0] seg_d [256];
        logic prev_prog, prev_clr, prev_hold, hold_now, finished, aborted, exp_fail;
        logic [11:0] sum;
        sum = 12'd0;
        for (int k = 0; k < n; k++) sum = sum + words[k];
        exp_fail = 1'b0;
`ifdef SAP2_LOADER_CHECKSUM_EN
        chk_exp  = sum + 12'(chk_delta);
        exp_fail = (chk_delta != 0);
`endif
        cyc = 0; acc = 0; rises = 0; clr_hi = 0; clr_rises = 0; segs = 0;
        prev_prog = 1'b0; prev_clr = 1'b0; prev_hold = 1'b0;
        finished = 1'b0; aborted = 1'b0;
        @(negedge clk);
        start = 1'b1; len = 8'(n); abort = 1'b0; in_valid = 1'b0;
        while (cyc < 3000 && !finished && !aborted) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (done) begin
                finished = 1'b1;
            end else begin
                if (cpu_prog && !prev_prog) rises++;
                if (cpu_clr) clr_hi++;
                if (cpu_clr && !prev_clr) clr_rises++;
                hold_now = cpu_prog && !in_ready;
                if (hold_now && !prev_hold) begin
                    if (segs < 256) begin
                        seg_a[segs] = cpu_a; seg_d[segs] = cpu_d; seg_len[segs] = 1;
                    end
                    segs++;
                end else if (hold_now && segs > 0 && segs <= 256) begin
                    seg_len[segs-1]++;
                end
                prev_prog = cpu_prog; prev_clr = cpu_clr; prev_hold = hold_now;
                if (abort_seg > 0 && hold_now && segs == abort_seg) begin
                    abort = 1'b1;
                    in_valid = 1'b1;
                    start = 1'b1;
                    aborted = 1'b1;
                end else begin
                    case (mode)
                        0:       in_valid = 1'b1;
                        1:       in_valid = cyc[0];
                        default: in_valid = 1'($urandom_range(0, 1));
                    endcase
                    in_data = (acc < n) ? words[acc] : 12'($urandom);
                    if (in_valid && in_ready) acc++;
                    if (mode == 2 && busy) begin
                        start = 1'($urandom_range(0, 1));
                        len   = 8'($urandom);
                    end
                end
            end
        end
        if (aborted) begin
            @(negedge clk);
            abort = 1'b0; start = 1'b0; in_valid = 1'b0;
            check("abort_busy", busy, 0);
            check("abort_done", done, 0);
            check("abort_prog", cpu_prog, 0);
            check("abort_clr_on", cpu_clr, 1);
            check("abort_ready", in_ready, 0);
            check("abort_result", result, model_result);
            @(negedge clk);
            check("abort_clr_off", cpu_clr, 0);
            check("abort_idle_busy", busy, 0);
            for (int k = 0; k < abort_seg; k++) exp_mem[k] = words[k];
        end else begin
            in_valid = 1'b0;
            check("done_seen", finished, 1);
            check("busy_at_done", busy, 0);
            check("words_accepted", acc, n);
            check("hold_segments", segs, n);
            for (int k = 0; k < n && k < segs; k++) begin
                check($sformatf("seg%0d_addr", k), seg_a[k], k);
                check($sformatf("seg%0d_data", k), seg_d[k], words[k]);
                check($sformatf("seg%0d_len", k), seg_len[k], HOLD);
            end
            check("prog_rises", rises, (n > 0) ? 1 : 0);
            check("clr_cycles", clr_hi, exp_fail ? CLRC : 2 * CLRC);
            check("clr_pulses", clr_rises, (n > 0 && !exp_fail) ? 2 : 1);
            for (int k = 0; k < n; k++) exp_mem[k] = words[k];
            if (!exp_fail) model_result = exp_mem[(RUN - 1) & 7];
            check("result", result, model_result);
            if (n == 0 && !exp_fail) check("len0_latency", cyc, 2 * CLRC + RUN + 1);
`ifdef SAP2_LOADER_CHECKSUM_EN
            check("chk_err", chk_err, exp_fail);
            check("chk_sum", chk, sum);
`endif
        end
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; len = 8'd0; abort = 1'b0; in_valid = 1'b0; in_data = 12'd0;
`ifdef SAP2_LOADER_CHECKSUM_EN
        chk_exp = 12'd0;
`endif
        for (int i = 0; i < 256; i++) exp_mem[i] = init_val(i);
        model_result = 12'd0;

        // Reset
        repeat (2) @(negedge clk);
        check("rst_ready", in_ready, 0);
        check("rst_prog", cpu_prog, 0);
        check("rst_clr", cpu_clr, 0);
        check("rst_a", cpu_a, 0);
        check("rst_d", cpu_d, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        clr = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Directed image, valid always high
        words[0] = 12'h007; words[1] = 12'h108; words[2]  = 12'h109; words[3] = 12'h20A;
        words[4] = 12'hFE0; words[5] = 12'hFF0; words[6]  = 12'hFFF; words[7] = 12'h001;
        words[8] = 12'h002; words[9] = 12'h003; words[10] = 12'h004;
        run_job(11, 0, 0, 0);

        // abort while DONE has no effect
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_in_done_done", done, 1);
        check("abort_in_done_clr", cpu_clr, 0);

        // Same image with toggling valid
        run_job(11, 1, 0, 0);

        // Random images with random backpressure and stray start/len while busy
        for (int j = 0; j < 3; j++) begin
            int n;
            n = $urandom_range(1, 20);
            for (int k = 0; k < n; k++) words[k] = 12'($urandom);
            run_job(n, 2, 0, 0);
        end

        // Empty load: runs the old image
        run_job(0, 1, 0, 0);

        // Abort on the fourth word's hold, then a fresh job
        for (int k = 0; k < 11; k++) words[k] = 12'($urandom);
        run_job(11, 0, 4, 0);
        for (int k = 0; k < 6; k++) words[k] = 12'($urandom);
        run_job(6, 2, 0, 0);

`ifdef SAP2_LOADER_CHECKSUM_EN
        words[0] = 12'h001; words[1] = 12'h002;
        run_job(2, 0, 0, 0);
        run_job(2, 0, 0, 1);
`endif

        // Asynchronous reset in the middle of a load
        @(negedge clk);
        for (int k = 0; k < 5; k++) words[k] = 12'($urandom);
        start = 1'b1; len = 8'd5; in_valid = 1'b1; in_data = words[0];
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 clr = 1'b1;
        #1;
        check("async_busy", busy, 0);
        check("async_prog", cpu_prog, 0);
        check("async_a", cpu_a, 0);
        check("async_done", done, 0);
        check("async_result", result, 0);
        in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
